mem_responder: RTL and testbench

//  Memory-side responder for the multicycle core's memRead/memWrite strobes.
//  - Owns a word-organised RAM and answers loads and stores with a configurable wait-state latency.
//  - Returns sized, sign- or zero-extended load data and a one-cycle ready pulse.
//  - Raises a sticky error that feeds the control unit's error input, which forces its HALT state.

---
 rtl/mem_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle core's memRead/memWrite strobes.
// Owns a word-organised RAM. Loads and stores complete after a configurable
// number of wait states. Loads return byte, half or word data with sign or
// zero extension. A sticky error flag feeds the control unit's HALT input.
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of 2)
//   WAIT_STATES  extra cycles between request accept and ready (0..15)
//   BASE_ADDR    byte address of word 0 (DEPTH_WORDS*4 aligned)
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   memRead   in   1   load request, sampled only in IDLE
//   memWrite  in   1   store request, sampled only in IDLE
//   addr      in   32  byte address
//   wdata     in   32  store data, LSB-aligned
//   size      in   2   00 byte, 01 half, 10 word, 11 illegal
//   uns       in   1   1 = zero-extend load, 0 = sign-extend
//   rdata     out  32  load result, held until the next completed load
//   ready     out  1   one-cycle completion pulse
//   busy      out  1   high from accept until ready, inclusive
//   error     out  1   sticky fault flag, cleared only by rst
//
// Optional feature macro: MEM_MISALIGN_ERR_EN
//   Defined   : misaligned half/word accesses are faults.
//   Undefined : low address bits are forced to alignment instead.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int          IDXW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDXW-1:0]   idxQ;
    logic [1:0]        laneQ;
    logic [1:0]        sizeQ;
    logic              unsQ;
    logic              writeQ;
    logic [31:0]       wdataQ;

    logic [31:0]       mem [DEPTH_WORDS];

    // Request decode. The offset from BASE_ADDR wraps for addresses below
    // the base, so a single unsigned compare covers both ends of the window.
    logic [31:0]       off;
    logic              inRange;
    logic              req;
    logic              fault;
    logic [1:0]        liveLane;
    logic [IDXW-1:0]   liveIdx;

    assign off     = addr - BASE_ADDR;
    assign inRange = ({1'b0, off} < SPAN);
    assign req     = memRead | memWrite;
    assign liveIdx = off[IDXW+1:2];

`ifdef MEM_MISALIGN_ERR_EN
    logic misaligned;
    assign misaligned = ((size == 2'b01) && off[0]) ||
                        ((size == 2'b10) && (off[1:0] != 2'b00));
    assign fault      = (memRead & memWrite) | (size == 2'b11) | ~inRange | misaligned;
    assign liveLane   = off[1:0];
`else
    assign fault      = (memRead & memWrite) | (size == 2'b11) | ~inRange;
    assign liveLane   = (size == 2'b01) ? {off[1], 1'b0} :
                        (size == 2'b10) ? 2'b00 : off[1:0];
`endif

    // With zero wait states the response is produced straight from IDLE,
    // before anything is latched, so the read path uses the live request.
    logic [IDXW-1:0]   effIdx;
    logic [1:0]        effLane;
    logic [1:0]        effSize;
    logic              effUns;
    logic [31:0]       readWord;

    assign effIdx   = (state == IDLE) ? liveIdx  : idxQ;
    assign effLane  = (state == IDLE) ? liveLane : laneQ;
    assign effSize  = (state == IDLE) ? size     : sizeQ;
    assign effUns   = (state == IDLE) ? uns      : unsQ;
    assign readWord = mem[effIdx];

    function automatic logic [31:0] extendLoad(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane,
                                               input logic        u);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[8*lane +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = u ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = u ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    logic [31:0] loadResult;
    assign loadResult = extendLoad(readWord, effSize, effLane, effUns);

    // Main control FSM. ready, busy, rdata and error are all registered and
    // change on the edge that enters the corresponding state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rdata  <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            error  <= 1'b0;
            idxQ   <= '0;
            laneQ  <= '0;
            sizeQ  <= '0;
            unsQ   <= 1'b0;
            writeQ <= 1'b0;
            wdataQ <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (fault) begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idxQ   <= liveIdx;
                            laneQ  <= liveLane;
                            sizeQ  <= size;
                            unsQ   <= uns;
                            writeQ <= memWrite;
                            wdataQ <= wdata;
                            busy   <= 1'b1;
                            if (WAIT_STATES == 0) begin
                                state <= RESP;
                                ready <= 1'b1;
                                if (!memWrite) rdata <= loadResult;
                            end else begin
                                state <= WAIT;
                                cnt   <= 4'(WAIT_STATES - 1);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                        if (!writeQ) rdata <= loadResult;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store lane steering: the LSBs of wdata are replicated across the word
    // and the byte enables pick which copy lands in RAM.
    logic [3:0]  be;
    logic [31:0] steer;

    always_comb begin
        be    = 4'b0000;
        steer = wdataQ;
        case (sizeQ)
            2'b00: begin
                be    = 4'b0001 << laneQ;
                steer = {4{wdataQ[7:0]}};
            end
            2'b01: begin
                be    = laneQ[1] ? 4'b1100 : 4'b0011;
                steer = {2{wdataQ[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                steer = wdataQ;
            end
        endcase
    end

    // RAM write happens on the edge that leaves RESP; a reset on that same
    // edge discards the store. RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && (state == RESP) && writeQ) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idxQ][8*b +: 8] <= steer[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Directed self-checking bench for mem_responder with WAIT_STATES=1 and the
// default 4096-word RAM at base 0. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;

    mem_responder #(
        .DEPTH_WORDS(4096),
        .WAIT_STATES(1),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memRead (memRead),
        .memWrite(memWrite),
        .addr    (addr),
        .wdata   (wdata),
        .size    (size),
        .uns     (uns),
        .rdata   (rdata),
        .ready   (ready),
        .busy    (busy),
        .error   (error)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check in the bench is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one request for exactly one cycle, returning #1 after the
    // edge that samples it.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [1:0] sz, input logic u);
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = wd;
        size     = sz;
        uns      = u;
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    // Waits (bounded) for ready after an accepted request and checks that
    // ready comes 1+WAIT_STATES = 2 cycles after the request cycle.
    task automatic awaitReady(input string tag);
        int cycles = 0;
        checkOutput({tag, ".busyAccept"}, {31'b0, busy}, 32'd1);
        while (!ready && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, ".latency"}, 32'(cycles + 1), 32'd2);
        checkOutput({tag, ".busyReady"}, {31'b0, busy}, 32'd1);
    endtask

    // The cycle after RESP must show ready and busy both low.
    task automatic endResp(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, ".readyPulse"}, {31'b0, ready}, 32'd0);
        checkOutput({tag, ".busyDrop"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic doStore(input string tag, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz);
        applyStimulus(1'b0, 1'b1, a, wd, sz, 1'b0);
        awaitReady(tag);
        endResp(tag);
    endtask

    task automatic doLoad(input string tag, input logic [31:0] a,
                          input logic [1:0] sz, input logic u,
                          input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, a, 32'h0, sz, u);
        awaitReady(tag);
        checkOutput({tag, ".rdata"}, rdata, expected);
        endResp(tag);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Checks that a faulting request lands in ERR, stays there, and never
    // produces a ready pulse.
    task automatic expectFault(input string tag, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] sz);
        applyStimulus(rd, wr, a, wd, sz, 1'b0);
        checkOutput({tag, ".error"}, {31'b0, error}, 32'd1);
        checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput({tag, ".noReady"}, {31'b0, ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput({tag, ".errorHeld"}, {31'b0, error}, 32'd1);
        pulseReset();
        checkOutput({tag, ".errorCleared"}, {31'b0, error}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        addr     = '0;
        wdata    = '0;
        size     = 2'b10;
        uns      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("reset.rdata", rdata, 32'h0);
        checkOutput("reset.ready", {31'b0, ready}, 32'd0);
        checkOutput("reset.busy", {31'b0, busy}, 32'd0);
        checkOutput("reset.error", {31'b0, error}, 32'd0);
        rst = 1'b0;

        // Known background words for later no-change checks.
        doStore("seed0", 32'h0000_0000, 32'h1111_1111, 2'b10);
        doStore("seed20", 32'h0000_0020, 32'h600D_F00D, 2'b10);

        // Word store then word load.
        doStore("t1.store", 32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
        doLoad("t1.load", 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF);

        // Byte loads with both extensions.
        doLoad("t2.byteSigned", 32'h0000_0013, 2'b00, 1'b0, 32'hFFFF_FFDE);
        doLoad("t2.byteUns", 32'h0000_0013, 2'b00, 1'b1, 32'h0000_00DE);

        // Half store into the upper lane leaves the lower half alone.
        doStore("t3.storeHalf", 32'h0000_0012, 32'h0000_1234, 2'b01);
        doLoad("t3.loadWord", 32'h0000_0010, 2'b10, 1'b0, 32'h1234_BEEF);
        doLoad("t3.halfSigned", 32'h0000_0010, 2'b01, 1'b0, 32'hFFFF_BEEF);
        doLoad("t3.byteLow", 32'h0000_0010, 2'b00, 1'b1, 32'h0000_00EF);

        // Faults: conflicting strobes, then an address one past the top.
        expectFault("t4.both", 1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 2'b10);
        doLoad("t4.noWrite", 32'h0000_0010, 2'b10, 1'b0, 32'h1234_BEEF);
        expectFault("t4.range", 1'b0, 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 2'b10);
        doLoad("t4.noAlias", 32'h0000_0000, 2'b10, 1'b0, 32'h1111_1111);
        expectFault("t4.size11", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 2'b11);

        // Misaligned word load.
`ifdef MEM_MISALIGN_ERR_EN
        expectFault("t5.misalign", 1'b1, 1'b0, 32'h0000_0011, 32'h0, 2'b10);
`else
        doLoad("t5.forceAlign", 32'h0000_0011, 2'b10, 1'b0, 32'h1234_BEEF);
        checkOutput("t5.noError", {31'b0, error}, 32'd0);
`endif

        // Reset during the wait state of a store discards it and clears rdata.
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 2'b10, 1'b0);
        checkOutput("t6.inWait", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6.rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("t6.rstReady", {31'b0, ready}, 32'd0);
        checkOutput("t6.rstRdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("t6.rstReady2", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        doLoad("t6.oldValue", 32'h0000_0020, 2'b10, 1'b0, 32'h600D_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
